pc_sequencer: RTL and testbench

Program-counter sequencer feeding the instruction fetch stage of the ARM32 pipeline. It holds the architectural fetch PC, advances it by one word per cycle, and honours stalls and taken-branch redirects. It produces pipeline-aligned valid, PC and flush qualifiers that travel with the registered instruction word returned by fetch.

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-side bus between the pipeline and the PC sequencer
// master is the pipeline (hazard/execute/decode), slave is the sequencer.
interface pc_sequencer_if;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] pc;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc8;
   logic        flush;
   logic        pc_fault;
   logic [31:0] fetch_count;

   modport master (
      output stall, branch_taken, branch_target,
      input  pc, instr_valid, instr_pc, instr_pc8, flush, pc_fault, fetch_count
   );

   modport slave (
      input  stall, branch_taken, branch_target,
      output pc, instr_valid, instr_pc, instr_pc8, flush, pc_fault, fetch_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with stall, redirect and bad-target fault
// Qualifiers are registered so they line up with the word fetch returns one cycle after pc.
module pc_sequencer #(
   parameter int          CODE_WORDS = 512,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input logic           clk,
   input logic           resetn,
   pc_sequencer_if.slave bus
);

   localparam logic [31:0] PC_LIMIT = 32'(CODE_WORDS * 4);

   typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic [31:0] instr_pc8_q, instr_pc8_d;
   logic        flush_q, flush_d;
   logic        pc_fault_q, pc_fault_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] pc_inc;
   logic        target_bad;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_valid_d = instr_valid_q;
      instr_pc_d    = instr_pc_q;
      flush_d       = 1'b0;
      pc_fault_d    = pc_fault_q;
      pc_inc        = (pc_q + 32'd4 == PC_LIMIT) ? 32'd0 : pc_q + 32'd4;
      target_bad    = (bus.branch_target[1:0] != 2'b00) || (bus.branch_target >= PC_LIMIT);
      fetch_count_d = fetch_count_q + {31'd0, instr_valid_q & ~bus.stall};

      unique case (state_q)
         BOOT: begin
            // One dead cycle hides fetch's reset output word.
            state_d       = RUN;
            pc_d          = RESET_PC;
            instr_valid_d = 1'b0;
         end
         RUN, REDIRECT: begin
            if (bus.branch_taken) begin
               state_d       = REDIRECT;
               pc_d          = target_bad ? RESET_PC : {bus.branch_target[31:2], 2'b00};
               pc_fault_d    = pc_fault_q | target_bad;
               instr_valid_d = 1'b0;
               instr_pc_d    = pc_q;
               flush_d       = 1'b1;
            end else if (state_q == REDIRECT) begin
               // A stalled target word is delivered once, after the stall drops.
               state_d       = RUN;
               instr_valid_d = ~bus.stall;
               instr_pc_d    = pc_q;
               if (!bus.stall) begin
                  pc_d = pc_inc;
               end
            end else if (!bus.stall) begin
               pc_d          = pc_inc;
               instr_valid_d = 1'b1;
               instr_pc_d    = pc_q;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      instr_pc8_d = instr_pc_d + 32'd8;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         instr_valid_q <= 1'b0;
         instr_pc_q    <= RESET_PC;
         instr_pc8_q   <= RESET_PC + 32'd8;
         flush_q       <= 1'b0;
         pc_fault_q    <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
         instr_pc_q    <= instr_pc_d;
         instr_pc8_q   <= instr_pc8_d;
         flush_q       <= flush_d;
         pc_fault_q    <= pc_fault_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_pc8   = instr_pc8_q;
   assign bus.flush       = flush_q;
   assign bus.pc_fault    = pc_fault_q;
   assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and random checks of pc_sequencer against a cycle model
module tb_pc_sequencer;
   localparam int          CW  = 512;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   pc_sequencer_if bus ();

   pc_sequencer #(.CODE_WORDS(CW), .RESET_PC(RPC)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference: cycles since reset, whether the last accepted cycle redirected.
   int          m_age;
   bit          m_redir;
   logic [31:0] m_pc, m_ipc, m_cnt;
   bit          m_valid, m_flush, m_fault;

   task automatic model_reset();
      m_age = 0; m_redir = 0;
      m_pc = RPC; m_ipc = RPC; m_cnt = 0;
      m_valid = 0; m_flush = 0; m_fault = 0;
   endtask

   task automatic model_update(input bit s, input bit b, input logic [31:0] t);
      bit bad;
      bad = (t % 4 != 0) || (t >= CW * 4);
      if (m_valid && !s) m_cnt = m_cnt + 1;
      if (m_age == 0) begin
         m_age = 1; m_pc = RPC; m_valid = 0; m_flush = 0;
      end else if (b) begin
         m_pc = bad ? RPC : (t & ~32'd3);
         m_fault = m_fault | bad;
         m_valid = 0; m_flush = 1; m_redir = 1;
      end else if (m_redir) begin
         m_redir = 0; m_flush = 0;
         m_valid = !s; m_ipc = m_pc;
         if (!s) m_pc = (m_pc + 4) % (CW * 4);
      end else if (s) begin
         m_flush = 0;
      end else begin
         m_flush = 0; m_valid = 1; m_ipc = m_pc;
         m_pc = (m_pc + 4) % (CW * 4);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("pc", bus.pc, m_pc);
      check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid});
      check("flush", {31'd0, bus.flush}, {31'd0, m_flush});
      check("pc_fault", {31'd0, bus.pc_fault}, {31'd0, m_fault});
      check("fetch_count", bus.fetch_count, m_cnt);
      if (m_valid) begin
         check("instr_pc", bus.instr_pc, m_ipc);
         check("instr_pc8", bus.instr_pc8, m_ipc + 32'd8);
      end
   endtask

   task automatic step(input bit s, input bit b, input logic [31:0] t);
      bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
      @(posedge clk);
      model_update(s, b, t);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      model_reset();
      check_all();
      check("reset_instr_pc", bus.instr_pc, RPC);
      check("reset_instr_pc8", bus.instr_pc8, RPC + 32'd8);
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++) begin
         bit          s, b;
         logic [31:0] t;
         int          kind;
         s = ($urandom_range(3) == 0);
         b = ($urandom_range(9) == 0);
         kind = $urandom_range(9);
         if (kind < 7)       t = $urandom_range(CW - 1) * 4;
         else if (kind == 7) t = $urandom_range(CW * 4 - 1) | 32'd1;
         else if (kind == 8) t = CW * 4 + $urandom_range(64) * 4;
         else                t = $urandom;
         step(s, b, t);
      end
   endtask

   initial begin
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'd0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Reset release, then run to pc 0x10.
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      check("boot_pc", bus.pc, 32'h10);
      check("boot_ipc", bus.instr_pc, 32'h0C);
      check("boot_count", bus.fetch_count, 32'd3);

      // Stall three cycles at 0x10.
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      check("stall_pc", bus.pc, 32'h10);
      check("stall_count", bus.fetch_count, 32'd3);
      step(0, 0, 0);
      check("resume_pc", bus.pc, 32'h14);

      // Branch with stall at pc 0x20.
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      check("pre_branch_pc", bus.pc, 32'h20);
      step(1, 1, 32'h40);
      check("br_pc", bus.pc, 32'h40);
      check("br_flush", {31'd0, bus.flush}, 32'd1);
      step(0, 0, 0);
      check("br_ipc", bus.instr_pc, 32'h40);

      // Back-to-back branches.
      step(0, 1, 32'h80);
      check("b2b_pc1", bus.pc, 32'h80);
      step(0, 1, 32'hC0);
      check("b2b_pc2", bus.pc, 32'hC0);
      check("b2b_flush2", {31'd0, bus.flush}, 32'd1);
      step(0, 0, 0);
      check("b2b_ipc", bus.instr_pc, 32'hC0);

      // Wrap at the top of code memory.
      step(0, 1, 32'h7F8);
      step(0, 0, 0);
      step(0, 0, 0);
      check("wrap_pc", bus.pc, 32'h0);
      check("wrap_ipc8_hi", bus.instr_pc8, 32'h804);
      step(0, 0, 0);
      check("wrap_ipc8_lo", bus.instr_pc8, 32'h008);

      // Faulting targets and sticky fault.
      step(0, 1, 32'h42);
      check("fault_pc", bus.pc, RPC);
      check("fault_flag", {31'd0, bus.pc_fault}, 32'd1);
      step(0, 1, 32'h100);
      check("post_fault_pc", bus.pc, 32'h100);
      step(0, 1, 32'h800);
      check("range_fault_pc", bus.pc, RPC);
      step(0, 0, 0);
      step(0, 0, 0);

      random_run(2000);

      // Mid-operation reset; branch during BOOT is ignored.
      #2;
      do_reset();
      check("rst_fault", {31'd0, bus.pc_fault}, 32'd0);
      step(0, 1, 32'h40);
      check("boot_branch_pc", bus.pc, RPC);
      step(0, 0, 0);
      check("first_valid_ipc", bus.instr_pc, RPC);

      random_run(500);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
